// File: rtl/dly_write_sched.sv
// dly_write_sched: cycle-based scheduler for delayed register writes (q <= #d v).
// Requests (delay, data) park in a small slot table, count down once per cycle, and
// commit to a shared output register when their countdown has reached zero. When
// several slots are due together, the lowest index commits first. At most one
// commit happens per cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake; accepted when both are high
//   req_delay, req_data delay in cycles and the value to write
//   flush               synchronous discard of every pending write
//   out_valid           one-cycle pulse marking an update of out_value
//   out_value           committed register value (holds between writes)
//   out_slot            slot index of the most recent commit
//   pending             number of occupied slots
module dly_write_sched #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLOTS = 4,
  parameter int unsigned DLY_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [DLY_W-1:0]           req_delay,
  input  logic [WIDTH-1:0]           req_data,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_value,
  output logic [$clog2(SLOTS)-1:0]   out_slot,
  output logic [$clog2(SLOTS+1)-1:0] pending
);

  localparam int unsigned IDX_W = $clog2(SLOTS);
  localparam int unsigned CNT_W = $clog2(SLOTS + 1);

  // Slot table
  logic [SLOTS-1:0] busy_q, busy_d;
  logic [DLY_W-1:0] cnt_q  [SLOTS];
  logic [DLY_W-1:0] cnt_d  [SLOTS];
  logic [WIDTH-1:0] data_q [SLOTS];
  logic [WIDTH-1:0] data_d [SLOTS];

  // Output register
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_value_q, out_value_d;
  logic [IDX_W-1:0] out_slot_q,  out_slot_d;

  logic [SLOTS-1:0] due;
  logic             commit;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] alloc_idx;
  logic             accept;
  logic [CNT_W-1:0] busy_cnt;

  // Commit arbitration: lowest-index due slot wins. Scanning downwards lets the
  // last assignment (lowest index) take effect.
  always_comb begin
    due     = '0;
    commit  = 1'b0;
    win_idx = '0;
    for (int i = 0; i < SLOTS; i++) begin
      due[i] = busy_q[i] && (cnt_q[i] == '0);
    end
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (due[i]) begin
        commit  = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end

  // Allocation: lowest-index free slot. Based on registered busy bits only, so a
  // slot freed by this cycle's commit is not reusable until the next cycle.
  always_comb begin
    alloc_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_idx = IDX_W'(i);
      end
    end
  end

  assign req_ready = ~&busy_q;
  assign accept    = req_valid && req_ready && !flush;

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < SLOTS; i++) begin
      busy_cnt = busy_cnt + CNT_W'(busy_q[i]);
    end
  end

  // Next-state for slot table and output register
  always_comb begin
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    out_valid_d = 1'b0;
    out_value_d = out_value_q;
    out_slot_d  = out_slot_q;

    // Countdowns saturate at zero; due slots that lost arbitration stay due.
    for (int i = 0; i < SLOTS; i++) begin
      if (busy_q[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - DLY_W'(1);
      end
    end

    if (commit && !flush) begin
      busy_d[win_idx] = 1'b0;
      out_valid_d     = 1'b1;
      out_value_d     = data_q[win_idx];
      out_slot_d      = win_idx;
    end

    // alloc_idx is never busy, so it cannot collide with the commit winner.
    if (accept) begin
      busy_d[alloc_idx] = 1'b1;
      cnt_d[alloc_idx]  = req_delay;
      data_d[alloc_idx] = req_data;
    end

    if (flush) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_slot_q  <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        cnt_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_slot_q  <= out_slot_d;
      for (int i = 0; i < SLOTS; i++) begin
        cnt_q[i]  <= cnt_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_slot  = out_slot_q;
  assign pending   = busy_cnt;

endmodule

// File: tb/tb_dly_write_sched.sv
module tb_dly_write_sched;

  localparam int WIDTH = 32;
  localparam int SLOTS = 4;
  localparam int DLY_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [DLY_W-1:0] req_delay = '0;
  logic [WIDTH-1:0] req_data = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_value;
  logic [1:0]       out_slot;
  logic [2:0]       pending;

  dly_write_sched #(
    .WIDTH(WIDTH),
    .SLOTS(SLOTS),
    .DLY_W(DLY_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_delay(req_delay),
    .req_data (req_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_value(out_value),
    .out_slot (out_slot),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; read only on falling edges.
  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  typedef struct {
    logic [WIDTH-1:0] val;
    logic [1:0]       slot;
    int               cyc;
  } exp_t;

  typedef struct {
    logic [DLY_W-1:0] d;
    logic [WIDTH-1:0] v;
    logic [1:0]       slot;
  } vec_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] last_val = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ncyc);
    end
  endtask

  // Commit monitor: every out_valid pulse must match the head of the scoreboard,
  // including the edge it lands on.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_commit", 64'(out_valid), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("commit_value", 64'(out_value), 64'(mon_e.val));
        chk("commit_slot", 64'(out_slot), 64'(mon_e.slot));
        chk("commit_edge", 64'(ncyc), 64'(mon_e.cyc));
        last_val = mon_e.val;
      end
    end
  end

  // Present a request on the next falling edge; it is taken at the following
  // rising edge E0 and should commit at E0+d+1 (+extra if it loses arbitration).
  task automatic send(input logic [DLY_W-1:0] d, input logic [WIDTH-1:0] v,
                      input logic [1:0] slot, input int extra, input bit push);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_delay = d;
    req_data  = v;
    chk("req_ready", 64'(req_ready), 64'(1));
    if (push) begin
      e.val  = v;
      e.slot = slot;
      e.cyc  = ncyc + 1 + int'(d) + 1 + extra;
      sb.push_back(e);
    end
  endtask

  task automatic release_req();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Idle for up to n cycles, checking out_value holds between commits.
  task automatic run(input int n, input bit until_empty);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!out_valid) chk("hold", 64'(out_value), 64'(last_val));
      if (until_empty && sb.size() == 0) break;
    end
    if (until_empty) chk("drain", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];
  int   e0;

  initial begin
    tbl[0] = '{d: 8'd0,   v: 32'h0000_0011, slot: 2'd0};
    tbl[1] = '{d: 8'd55,  v: 32'h0000_0055, slot: 2'd0};
    tbl[2] = '{d: 8'd1,   v: 32'h0000_1234, slot: 2'd0};
    tbl[3] = '{d: 8'd255, v: 32'hFFFF_FFFF, slot: 2'd0};
    tbl[4] = '{d: 8'd7,   v: 32'h0000_0000, slot: 2'd0};
    tbl[5] = '{d: 8'd2,   v: 32'hA5A5_5A5A, slot: 2'd0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_value", 64'(out_value), 64'(0));
    chk("rst_out_slot", 64'(out_slot), 64'(0));
    chk("rst_pending", 64'(pending), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(1));

    // Single writes across a range of delays, including 0 and the maximum
    foreach (tbl[i]) begin
      send(tbl[i].d, tbl[i].v, tbl[i].slot, 0, 1'b1);
      release_req();
      run(300, 1'b1);
      chk("idle_pending", 64'(pending), 64'(0));
      chk("idle_ready", 64'(req_ready), 64'(1));
    end

    // Fill all slots, then hold a fifth request until a commit frees slot 0
    send(8'd10, 32'hF0, 2'd0, 0, 1'b1);
    e0 = ncyc + 1;
    send(8'd10, 32'hF1, 2'd1, 0, 1'b1);
    send(8'd10, 32'hF2, 2'd2, 0, 1'b1);
    send(8'd10, 32'hF3, 2'd3, 0, 1'b1);
    @(negedge clk);
    req_valid = 1'b1;
    req_delay = 8'd10;
    req_data  = 32'hF4;
    chk("full_ready", 64'(req_ready), 64'(0));
    chk("full_pending", 64'(pending), 64'(4));
    sb.push_back('{val: 32'hF4, slot: 2'd0, cyc: e0 + 23});
    for (int n = 0; n < 40 && !req_ready; n++) begin
      @(negedge clk);
      if (!req_ready) chk("stalled_pending", 64'(pending), 64'(4));
    end
    chk("fifth_accept_edge", 64'(ncyc + 1), 64'(e0 + 12));
    release_req();
    chk("fifth_pending", 64'(pending), 64'(3));
    run(60, 1'b1);

    // Same-edge due: slot 0 wins, slot 1 commits one edge later
    send(8'd3, 32'h0000_000A, 2'd0, 0, 1'b1);
    send(8'd2, 32'h0000_000B, 2'd1, 1, 1'b1);
    release_req();
    run(30, 1'b1);
    chk("arb_final_value", 64'(out_value), 64'(32'hB));
    chk("arb_final_slot", 64'(out_slot), 64'(1));

    // Asynchronous reset mid-countdown discards pending writes
    send(8'd20, 32'h21, 2'd0, 0, 1'b0);
    send(8'd20, 32'h22, 2'd1, 0, 1'b0);
    release_req();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    last_val = '0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_out_value", 64'(out_value), 64'(0));
    chk("arst_out_slot", 64'(out_slot), 64'(0));
    chk("arst_pending", 64'(pending), 64'(0));
    chk("arst_ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    run(40, 1'b0);
    send(8'd0, 32'h77, 2'd0, 0, 1'b1);
    release_req();
    run(10, 1'b1);

    // Flush one cycle before the first commit; a request alongside it is dropped
    send(8'd6, 32'hC1, 2'd0, 0, 1'b0);
    send(8'd6, 32'hC2, 2'd1, 0, 1'b0);
    send(8'd6, 32'hC3, 2'd2, 0, 1'b0);
    release_req();
    repeat (2) @(negedge clk);
    chk("preflush_pending", 64'(pending), 64'(3));
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_delay = 8'd0;
    req_data  = 32'hDD;
    chk("flush_ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("flush_pending", 64'(pending), 64'(0));
    chk("flush_ready_after", 64'(req_ready), 64'(1));
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_value", 64'(out_value), 64'(32'h77));
    run(20, 1'b0);
    chk("flush_final_pending", 64'(pending), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dly_write_sched.md
# dly_write_sched

Synthesizable scheduler for delayed register writes, the cycle-based equivalent of the intra-assignment-delay nonblocking assignment `q <= #d v`. Requesters submit (delay, data) pairs. The block holds them in a small slot table, counts each one down, and commits it to a shared output register when its delay expires. When several writes expire together, the block arbitrates between them. It sits in front of any state register whose updates must land a programmable number of clock cycles after issue.

## Interface
- WIDTH, 32: data width of written values.
- SLOTS, 4: number of in-flight delayed writes (2..16).
- DLY_W, 8: width of delay field, in cycles.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  a free slot exists; request accepted on req_valid && req_ready.
- req_delay  in  DLY_W  delay in cycles, unsigned.
- req_data  in  WIDTH  value to write.
- flush  in  1  synchronous; discards all pending writes.
- out_valid  out  1  one-cycle pulse: out_value updated at this edge.
- out_value  out  WIDTH  committed register value; holds between writes.
- out_slot  out  $clog2(SLOTS)  slot index of the write committed at this edge.
- pending  out  $clog2(SLOTS+1)  number of occupied slots.

## Operation
- Slot state per entry: busy bit, countdown[DLY_W], data[WIDTH].
- Allocation: an accepted request goes to the lowest-index free slot, with countdown = req_delay.
- Each edge, every busy slot with countdown > 0 decrements by 1.
- A busy slot with countdown == 0 is due.
- Commit arbitration: fixed priority, lowest due index wins.
- The winner's data loads into out_value, out_valid=1, out_slot=index, and the slot frees.
- Losing due slots stay due at countdown 0 and compete again next edge. One commit per cycle at most.
- req_ready = !(all slots busy), computed from registered state only.
  - A slot freed by a commit becomes allocatable the following cycle, never the same cycle.
- Request and commit in the same cycle are both performed. pending = old + accept − commit.
- flush: all busy bits clear at the edge, no commit occurs that edge, and out_value is unchanged. A request presented with flush is discarded, and req_ready is still reported normally.
- Delay arithmetic is unsigned. There is no wrap-around: a countdown stops at 0. The maximum delay is 2^DLY_W−1.
- Reset (asynchronous, any time, including mid-countdown):
  - All slots are cleared, out_value=0, out_valid=0, out_slot=0, pending=0.
  - req_ready=1 once rst_n is high.
  - Pending writes are lost and never committed.

## Timing
- Request accepted at edge E0 with delay d: the earliest commit is at edge E0+d+1, so out_valid is high in cycle E0+d+1.
  - Latency is d+1 cycles; d=0 commits on the next edge.
  - The actual commit is later if a lower-index due slot is also present.
- out_valid is registered and high for exactly one cycle per commit. out_value changes only on edges where out_valid goes high.
- Back-to-back commits at one per cycle are sustained while due slots exist.
- Full-rate accept: one request per cycle while req_ready.
- A request with req_valid && !req_ready is not accepted. The requester must hold it, and no state changes for it.

## Test plan
- Reset, then request d=0, data=0x11 at E0 → out_valid at E1, out_value=0x11, out_slot=0, pending returns to 0.
- Request d=55, data=0x55 → out_valid exactly 56 cycles later, out_value=0x55. out_value holds its previous value throughout the wait.
- Fill all 4 slots with d=10 and present a 5th request → req_ready=0, pending=4, and the 5th is not accepted. The first commit frees a slot, the 5th is accepted one cycle after that commit, and it commits with correct data.
- Requests A (d=3, slot 0) then B (d=2, slot 1) on consecutive cycles, both due at the same edge → A commits first (out_value=A, out_slot=0), then B on the next edge. Final out_value=B.
- Two pending writes (d=20), rst_n pulsed low at cycle 5 → outputs drop to reset values immediately, and no out_valid ever follows. A new d=0 request after reset commits normally.
- Three pending writes, flush asserted one cycle before the first would commit → pending=0 next cycle, no out_valid, out_value unchanged, req_ready=1.
